// File: rtl/dp16x4_pkg.sv
// Shared constants and types for the 16x4 dual-port EBR FIFO controller.
package dp16x4_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 4;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [AW:0]   count_t;

endpackage

// File: rtl/dp16x4_rdvalid_pipe.sv
// Shift register that carries accepted pops alongside the memory read latency.
module dp16x4_rdvalid_pipe
    import dp16x4_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic pop_accept,
    output logic pop_valid
);

    logic [LATENCY-1:0] stage;

    // NOTE: only this valid pipeline is cleared; the read data path is left
    // unreset because a cleared valid bit already marks it as don't-care.
    always_ff @(posedge clk) begin
        if (clear) begin
            stage <= '0;
        end else begin
            stage[0] <= pop_accept;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_valid = stage[LATENCY-1];

endmodule

// File: rtl/dp16x4_fifo_ctrl.sv
// Single-clock FIFO controller driving the 16x4 dual-port EBR as a 16-deep FIFO,
// with occupancy flags and sticky overflow/underflow errors.
module dp16x4_fifo_ctrl
    import dp16x4_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int AF_LEVEL   = 14
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          PushEn,
    input  logic [DW-1:0] PushData,
    input  logic          PopEn,
    output logic [DW-1:0] PopData,
    output logic          PopValid,
    output logic          Full,
    output logic          Empty,
    output logic          AlmostFull,
    output logic [AW:0]   Count,
    output logic          Overflow,
    output logic          Underflow,
    output logic [DW-1:0] Data,
    output logic [AW-1:0] WrAddress,
    output logic          WrEn,
    output logic [AW-1:0] RdAddress,
    output logic          RdEn,
    input  logic [DW-1:0] Q
);

    localparam count_t FULL_CNT = count_t'(DEPTH);
    localparam count_t AF_CNT   = count_t'(AF_LEVEL);

    addr_t  wr_ptr;
    addr_t  rd_ptr;
    count_t count;
    logic   push_ok;
    logic   pop_ok;

    assign Full       = (count == FULL_CNT);
    assign Empty      = (count == '0);
    assign AlmostFull = (count >= AF_CNT);
    assign Count      = count;

    // Refusing the push while full keeps the write off the word being read.
    assign push_ok = PushEn & ~Full;
    assign pop_ok  = PopEn & ~Empty;

    assign Data      = PushData;
    assign WrAddress = wr_ptr;
    assign RdAddress = rd_ptr;
    assign WrEn      = push_ok & ~Reset;
    assign RdEn      = pop_ok & ~Reset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + addr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + addr_t'(1);
            end

            case ({push_ok, pop_ok})
                2'b10:   count <= count + count_t'(1);
                2'b01:   count <= count - count_t'(1);
                default: count <= count;
            endcase

            if (PushEn && !push_ok) begin
                Overflow <= 1'b1;
            end
            if (PopEn && !pop_ok) begin
                Underflow <= 1'b1;
            end
        end
    end

    dp16x4_rdvalid_pipe #(
        .LATENCY (RD_LATENCY)
    ) u_rdvalid_pipe (
        .clk        (Clock),
        .clear      (Reset),
        .pop_accept (pop_ok),
        .pop_valid  (PopValid)
    );

    assign PopData = Q;

endmodule

// File: tb/tb_dp16x4_fifo_ctrl.sv
// Directed bench: two controllers (read latency 1 and 2) share stimulus, each
// backed by a behavioural 16x4 memory model.
module tb_dp16x4_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       push_en;
    logic [3:0] push_data;
    logic       pop_en;

    // Instance with RD_LATENCY = 1
    logic [3:0] pop_data_1, data_1, q_1, wr_addr_1, rd_addr_1;
    logic       pop_valid_1, full_1, empty_1, af_1, ovf_1, unf_1, wr_en_1, rd_en_1;
    logic [4:0] count_1;

    // Instance with RD_LATENCY = 2
    logic [3:0] pop_data_2, data_2, q_2, q_2a, wr_addr_2, rd_addr_2;
    logic       pop_valid_2, full_2, empty_2, af_2, ovf_2, unf_2, wr_en_2, rd_en_2;
    logic [4:0] count_2;

    logic [3:0] mem_1 [16];
    logic [3:0] mem_2 [16];

    int n_checks = 0;
    int n_errors = 0;

    dp16x4_fifo_ctrl #(.RD_LATENCY(1), .AF_LEVEL(14)) u_dut_1 (
        .Clock(clk), .Reset(rst), .PushEn(push_en), .PushData(push_data), .PopEn(pop_en),
        .PopData(pop_data_1), .PopValid(pop_valid_1), .Full(full_1), .Empty(empty_1),
        .AlmostFull(af_1), .Count(count_1), .Overflow(ovf_1), .Underflow(unf_1),
        .Data(data_1), .WrAddress(wr_addr_1), .WrEn(wr_en_1), .RdAddress(rd_addr_1),
        .RdEn(rd_en_1), .Q(q_1)
    );

    dp16x4_fifo_ctrl #(.RD_LATENCY(2), .AF_LEVEL(14)) u_dut_2 (
        .Clock(clk), .Reset(rst), .PushEn(push_en), .PushData(push_data), .PopEn(pop_en),
        .PopData(pop_data_2), .PopValid(pop_valid_2), .Full(full_2), .Empty(empty_2),
        .AlmostFull(af_2), .Count(count_2), .Overflow(ovf_2), .Underflow(unf_2),
        .Data(data_2), .WrAddress(wr_addr_2), .WrEn(wr_en_2), .RdAddress(rd_addr_2),
        .RdEn(rd_en_2), .Q(q_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x4 EBR models: registered read, one extra output stage for latency 2.
    always @(posedge clk) begin
        if (wr_en_1) mem_1[wr_addr_1] <= data_1;
        if (rd_en_1) q_1 <= mem_1[rd_addr_1];
        if (wr_en_2) mem_2[wr_addr_2] <= data_2;
        if (rd_en_2) q_2a <= mem_2[rd_addr_2];
        q_2 <= q_2a;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic push, input logic [3:0] d, input logic pop);
        @(negedge clk);
        push_en   = push;
        push_data = d;
        pop_en    = pop;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Distinct data for words 0 and 16 so a wrapped read of a stale word shows up.
    function automatic logic [3:0] wdat(input int i);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(i * 7 + 3);
        b = 4'(i >> 4);
        return a ^ b;
    endfunction

    initial begin
        rst       = 1'b1;
        push_en   = 1'b0;
        push_data = 4'h0;
        pop_en    = 1'b0;

        // Reset: enables forced low even with requests present
        @(negedge clk);
        push_en = 1'b1;
        pop_en  = 1'b1;
        #1;
        check("wren_in_reset", wr_en_1, 0);
        check("rden_in_reset", rd_en_1, 0);
        do_reset();
        check("rst_count", count_1, 0);
        check("rst_empty", empty_1, 1);
        check("rst_full", full_1, 0);
        check("rst_af", af_1, 0);
        check("rst_popvalid", pop_valid_1, 0);
        check("rst_ovf", ovf_1, 0);
        check("rst_unf", unf_1, 0);

        // Three pushes
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 1'b0);
            check("push3_wren", wr_en_1, 1);
            check("push3_wraddr", wr_addr_1, i);
            check("push3_data", data_1, i + 1);
            tick();
            check("push3_empty", empty_1, 0);
        end
        check("push3_count", count_1, 3);

        // Fill to 16, AlmostFull threshold, then overflow
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 4'(k - 1), 1'b0);
            tick();
            check("fill_af", af_1, (k >= 14) ? 1 : 0);
        end
        check("fill_full", full_1, 1);
        check("fill_count", count_1, 16);
        drive(1'b1, 4'hE, 1'b0);
        check("ovf_wren", wr_en_1, 0);
        tick();
        check("ovf_flag", ovf_1, 1);
        check("ovf_count", count_1, 16);

        // Drain 16 at full rate
        for (int j = 0; j < 16; j++) begin
            drive(1'b0, 4'h0, 1'b1);
            check("drain_rden", rd_en_1, 1);
            check("drain_rdaddr", rd_addr_1, j);
            tick();
            check("drain_valid", pop_valid_1, 1);
            check("drain_data", pop_data_1, j);
        end
        check("drain_empty", empty_1, 1);
        check("drain_count", count_1, 0);
        drive(1'b0, 4'h0, 1'b1);
        check("unf_rden", rd_en_1, 0);
        tick();
        check("unf_valid", pop_valid_1, 0);
        check("unf_flag", unf_1, 1);
        check("unf_ovf_sticky", ovf_1, 1);

        // Wrap-around streaming at Count = 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, wdat(i), 1'b0);
            tick();
        end
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, wdat(k + 5), 1'b1);
            check("wrap_wraddr", wr_addr_1, (k + 5) % 16);
            check("wrap_rdaddr", rd_addr_1, k % 16);
            tick();
            check("wrap_count", count_1, 5);
            check("wrap_valid", pop_valid_1, 1);
            check("wrap_data", pop_data_1, wdat(k));
        end
        for (int k = 15; k < 20; k++) begin
            drive(1'b0, 4'h0, 1'b1);
            check("wrap_tail_rdaddr", rd_addr_1, k % 16);
            tick();
            check("wrap_tail_data", pop_data_1, wdat(k));
        end
        check("wrap_empty", empty_1, 1);

        // Simultaneous push+pop while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            tick();
        end
        drive(1'b1, 4'h5, 1'b1);
        check("full_both_wren", wr_en_1, 0);
        check("full_both_rden", rd_en_1, 1);
        tick();
        check("full_both_count", count_1, 15);
        check("full_both_ovf", ovf_1, 1);
        check("full_both_unf", unf_1, 0);
        check("full_both_data", pop_data_1, 0);

        // Simultaneous push+pop while empty, then read the word back next cycle
        do_reset();
        drive(1'b1, 4'h9, 1'b1);
        check("empty_both_wren", wr_en_1, 1);
        check("empty_both_rden", rd_en_1, 0);
        tick();
        check("empty_both_count", count_1, 1);
        check("empty_both_unf", unf_1, 1);
        check("empty_both_ovf", ovf_1, 0);
        check("empty_both_valid", pop_valid_1, 0);
        drive(1'b0, 4'h0, 1'b1);
        tick();
        check("wr_then_rd_valid", pop_valid_1, 1);
        check("wr_then_rd_data", pop_data_1, 9);

        // Latency 2: reset with two pops in flight
        do_reset();
        drive(1'b0, 4'h0, 1'b1);
        tick();
        check("l2_unf_set", unf_2, 1);
        drive(1'b1, 4'hA, 1'b0);
        tick();
        drive(1'b1, 4'hB, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b1);
        tick();
        check("l2_pop1_not_yet", pop_valid_2, 0);
        drive(1'b0, 4'h0, 1'b1);
        tick();
        check("l2_pop1_valid", pop_valid_2, 1);
        check("l2_pop1_data", pop_data_2, 4'hA);
        @(negedge clk);
        rst    = 1'b1;
        pop_en = 1'b0;
        tick();
        check("l2_flush_valid", pop_valid_2, 0);
        check("l2_flush_count", count_2, 0);
        check("l2_flush_empty", empty_2, 1);
        check("l2_flush_unf", unf_2, 0);
        check("l2_flush_ovf", ovf_2, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("l2_after_valid", pop_valid_2, 0);
        tick();
        check("l2_after_valid2", pop_valid_2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
